alu_seq_muldiv: RTL and testbench

- Parametrised, registered successor to the single-cycle datapath ALU.
- Keeps the ten existing operation encodings, which complete in one cycle.
- Adds iterative multiply and divide units with HI/LO registers, plus MFHI/MFLO.
- Sits in the execute stage of the multi-cycle core. It uses a valid/ready input handshake so the controller can stall while a multiply or divide is in flight.

---
 rtl/alu_seq_muldiv_if.sv | 27 ++
 rtl/alu_seq_muldiv.sv | 205 ++++++++++++++++++++
 tb/tb_alu_seq_muldiv.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_muldiv_if.sv
// Execute-stage ALU port bundle: request handshake from the controller, result/HI/LO back.
interface alu_seq_muldiv_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_WIDTH-1:0]  opSel;
    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] result;
    logic                  zero;
    logic                  busy;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output in_valid, opSel, operand1, operand2,
        input  in_ready, out_valid, result, zero, busy, hi, lo
    );

    modport slave (
        input  in_valid, opSel, operand1, operand2,
        output in_ready, out_valid, result, zero, busy, hi, lo
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Registered ALU with iterative MUL/DIV and HI/LO; divider built only under ALU_SEQ_DIV_EN.
// Latency: single ops 2 edges (capture, compute); mul/div DATA_WIDTH+1 edges after acceptance.
// Backpressure: in_ready low while a mul/div iterates or completes; held requests wait.
module alu_seq_muldiv #(
    parameter int DATA_WIDTH  = 32,
    parameter int SEL_WIDTH   = 4,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic            clk,
    input  logic            reset,
    alu_seq_muldiv_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [SEL_WIDTH-1:0] OP_ADD  = SEL_WIDTH'(4'h0);
    localparam logic [SEL_WIDTH-1:0] OP_SUB  = SEL_WIDTH'(4'h1);
    localparam logic [SEL_WIDTH-1:0] OP_AND  = SEL_WIDTH'(4'h2);
    localparam logic [SEL_WIDTH-1:0] OP_OR   = SEL_WIDTH'(4'h3);
    localparam logic [SEL_WIDTH-1:0] OP_SLT  = SEL_WIDTH'(4'h4);
    localparam logic [SEL_WIDTH-1:0] OP_XOR  = SEL_WIDTH'(4'h5);
    localparam logic [SEL_WIDTH-1:0] OP_NOR  = SEL_WIDTH'(4'h6);
    localparam logic [SEL_WIDTH-1:0] OP_SLL  = SEL_WIDTH'(4'h7);
    localparam logic [SEL_WIDTH-1:0] OP_SRL  = SEL_WIDTH'(4'h8);
    localparam logic [SEL_WIDTH-1:0] OP_SGT  = SEL_WIDTH'(4'h9);
    localparam logic [SEL_WIDTH-1:0] OP_MUL  = SEL_WIDTH'(4'hA);
    localparam logic [SEL_WIDTH-1:0] OP_MULU = SEL_WIDTH'(4'hB);
`ifdef ALU_SEQ_DIV_EN
    localparam logic [SEL_WIDTH-1:0] OP_DIV  = SEL_WIDTH'(4'hC);
    localparam logic [SEL_WIDTH-1:0] OP_DIVU = SEL_WIDTH'(4'hD);
`endif
    localparam logic [SEL_WIDTH-1:0] OP_MFHI = SEL_WIDTH'(4'hE);
    localparam logic [SEL_WIDTH-1:0] OP_MFLO = SEL_WIDTH'(4'hF);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state, state_nxt;
    logic                  accept, op_mul, op_div, op_multi, op_signed, iter_done;
    logic [DW-1:0]         a_mag, b_mag;

    logic                  s_pend_q, s_out_q;
    logic [SEL_WIDTH-1:0]  s_op_q;
    logic [DW-1:0]         s_a_q, s_b_q, single_res;

    logic [DW-1:0]         result_q, hi_q, lo_q;
    logic                  zero_q;

    logic [CW-1:0]         cnt_q;
    logic [DW-1:0]         acc_hi_q, acc_lo_q, b_q;
    logic                  neg_lo_q;
    logic [DW:0]           mul_sum;
    logic [2*DW-1:0]       prod, prod_s;
    logic [DW-1:0]         iter_hi, iter_lo, fin_hi, fin_lo;
`ifdef ALU_SEQ_DIV_EN
    logic                  is_div_q, neg_hi_q, dz_q;
    logic [DW:0]           div_shift, div_diff;
`endif

    // Request decode; operands are reduced to magnitudes so one unsigned engine serves both signednesses.
    always_comb begin
        accept = bus.in_valid && (state == IDLE) && !reset;
        op_mul = (bus.opSel == OP_MUL) || (bus.opSel == OP_MULU);
`ifdef ALU_SEQ_DIV_EN
        op_div    = (bus.opSel == OP_DIV) || (bus.opSel == OP_DIVU);
        op_signed = (bus.opSel == OP_MUL) || (bus.opSel == OP_DIV);
`else
        op_div    = 1'b0;
        op_signed = (bus.opSel == OP_MUL);
`endif
        op_multi = op_mul || op_div;
        a_mag = (op_signed && bus.operand1[DW-1]) ? -bus.operand1 : bus.operand1;
        b_mag = (op_signed && bus.operand2[DW-1]) ? -bus.operand2 : bus.operand2;
        iter_done = (cnt_q == CW'(DATA_WIDTH));
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && op_multi) state_nxt = BUSY;
            BUSY:    if (iter_done)          state_nxt = DONE;
            DONE:                            state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE) && !reset;
        bus.busy      = (state == BUSY);
        bus.out_valid = (state == DONE) || s_out_q;
        bus.result    = result_q;
        bus.zero      = zero_q;
        bus.hi        = hi_q;
        bus.lo        = lo_q;
    end

    always_comb begin
        single_res = '0;
        case (s_op_q)
            OP_ADD:  single_res = s_a_q + s_b_q;
            OP_SUB:  single_res = s_a_q - s_b_q;
            OP_AND:  single_res = s_a_q & s_b_q;
            OP_OR:   single_res = s_a_q | s_b_q;
            OP_XOR:  single_res = s_a_q ^ s_b_q;
            OP_NOR:  single_res = ~(s_a_q | s_b_q);
            OP_SLT:  single_res = {{(DW-1){1'b0}}, ($signed(s_a_q) < $signed(s_b_q))};
            OP_SGT:  single_res = {{(DW-1){1'b0}}, ($signed(s_a_q) > $signed(s_b_q))};
            OP_SLL:  single_res = s_b_q << s_a_q[SHAMT_WIDTH-1:0];
            OP_SRL:  single_res = s_b_q >> s_a_q[SHAMT_WIDTH-1:0];
            OP_MFHI: single_res = hi_q;
            OP_MFLO: single_res = lo_q;
            default: single_res = '0;
        endcase
    end

    // One shift-add (mul) or restoring-subtract (div) step per cycle on {acc_hi, acc_lo}.
    always_comb begin
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(DW+1){1'b0}});
        prod    = {acc_hi_q, acc_lo_q};
        prod_s  = neg_lo_q ? -prod : prod;
        iter_hi = mul_sum[DW:1];
        iter_lo = {mul_sum[0], acc_lo_q[DW-1:1]};
        fin_hi  = prod_s[2*DW-1:DW];
        fin_lo  = prod_s[DW-1:0];
`ifdef ALU_SEQ_DIV_EN
        div_shift = {acc_hi_q, acc_lo_q[DW-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (is_div_q) begin
            if (!div_diff[DW]) begin
                iter_hi = div_diff[DW-1:0];
                iter_lo = {acc_lo_q[DW-2:0], 1'b1};
            end else begin
                iter_hi = div_shift[DW-1:0];
                iter_lo = {acc_lo_q[DW-2:0], 1'b0};
            end
            // A zero divisor leaves remainder = |dividend|, so only the quotient needs overriding.
            fin_lo = dz_q ? {DW{1'b1}} : (neg_lo_q ? -acc_lo_q : acc_lo_q);
            fin_hi = neg_hi_q ? -acc_hi_q : acc_hi_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_pend_q <= 1'b0;
            s_out_q  <= 1'b0;
            s_op_q   <= '0;
            s_a_q    <= '0;
            s_b_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            b_q      <= '0;
            neg_lo_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            s_pend_q <= accept && !op_multi;
            s_out_q  <= s_pend_q;
            if (accept) begin
                s_op_q <= bus.opSel;
                s_a_q  <= bus.operand1;
                s_b_q  <= bus.operand2;
            end
            if (s_pend_q) begin
                result_q <= single_res;
                zero_q   <= (single_res == '0);
            end
            if (accept && op_multi) begin
                cnt_q    <= '0;
                acc_hi_q <= '0;
                acc_lo_q <= a_mag;
                b_q      <= b_mag;
                neg_lo_q <= op_signed && (bus.operand1[DW-1] ^ bus.operand2[DW-1]);
`ifdef ALU_SEQ_DIV_EN
                is_div_q <= op_div;
                neg_hi_q <= op_signed && bus.operand1[DW-1];
                dz_q     <= (bus.operand2 == '0);
`endif
            end else if (state == BUSY) begin
                if (!iter_done) begin
                    cnt_q    <= cnt_q + CW'(1);
                    acc_hi_q <= iter_hi;
                    acc_lo_q <= iter_lo;
                end else begin
                    hi_q     <= fin_hi;
                    lo_q     <= fin_lo;
                    result_q <= fin_lo;
                    zero_q   <= (fin_lo == '0);
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv at DATA_WIDTH=32; divide checks follow ALU_SEQ_DIV_EN.
module tb_alu_seq_muldiv;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NOR  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_SGT  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_MULU = 4'hB;
    localparam logic [3:0] OP_DIV  = 4'hC;
    localparam logic [3:0] OP_DIVU = 4'hD;
    localparam logic [3:0] OP_MFHI = 4'hE;
    localparam logic [3:0] OP_MFLO = 4'hF;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    alu_seq_muldiv_if #(.DATA_WIDTH(32), .SEL_WIDTH(4)) bus ();

    alu_seq_muldiv #(.DATA_WIDTH(32), .SEL_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        chk({tag, "_rdy"}, bus.in_ready, 1);
        bus.opSel = op; bus.operand1 = a; bus.operand2 = b; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk({tag, "_early"}, bus.out_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        tick();
        chk({tag, "_vld"}, bus.out_valid, 1);
        chk({tag, "_res"}, bus.result, exp);
        chk({tag, "_zero"}, bus.zero, (exp == 32'h0));
    endtask

    task automatic run_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        chk({tag, "_rdy"}, bus.in_ready, 1);
        bus.opSel = op; bus.operand1 = a; bus.operand2 = b; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 33);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_hi"}, bus.hi, ehi);
        chk({tag, "_lo"}, bus.lo, elo);
        chk({tag, "_res"}, bus.result, elo);
        tick();
        chk({tag, "_pulse"}, bus.out_valid, 0);
        chk({tag, "_idle"}, bus.in_ready, 1);
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.opSel = '0; bus.operand1 = '0; bus.operand2 = '0;
        tick();
        tick();
        chk("rst_ready_low", bus.in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_result", bus.result, 0);
        chk("rst_zero", bus.zero, 1);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_vld", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);

        // Back-to-back single-cycle ops: one result per cycle.
        bus.in_valid = 1'b1;
        bus.opSel = OP_ADD; bus.operand1 = 32'd7; bus.operand2 = 32'hFFFFFFF9;
        tick();
        bus.opSel = OP_SUB; bus.operand1 = 32'd5; bus.operand2 = 32'd9;
        tick();
        chk("b2b_add_vld", bus.out_valid, 1);
        chk("b2b_add_res", bus.result, 32'h0);
        chk("b2b_add_zero", bus.zero, 1);
        bus.opSel = OP_SLL; bus.operand1 = 32'd4; bus.operand2 = 32'd1;
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_sub_vld", bus.out_valid, 1);
        chk("b2b_sub_res", bus.result, 32'hFFFFFFFC);
        chk("b2b_sub_zero", bus.zero, 0);
        tick();
        chk("b2b_sll_vld", bus.out_valid, 1);
        chk("b2b_sll_res", bus.result, 32'h00000010);
        tick();
        chk("b2b_end_vld", bus.out_valid, 0);

        single("slt_neg", OP_SLT, 32'hFFFFFFFF, 32'd1, 32'd1);
        single("sgt_neg", OP_SGT, 32'hFFFFFFFF, 32'd1, 32'd0);
        single("srl_max", OP_SRL, 32'd31, 32'h80000000, 32'd1);
        single("sll_wrap", OP_SLL, 32'd36, 32'd1, 32'h00000010);
        single("nor_zero", OP_NOR, 32'h0, 32'h0, 32'hFFFFFFFF);

        // MUL with a different request held on in_valid throughout the iteration.
        bus.opSel = OP_MUL; bus.operand1 = 32'hFFFFFFFD; bus.operand2 = 32'd5; bus.in_valid = 1'b1;
        tick();
        chk("mul_busy0", bus.busy, 1);
        chk("mul_rdy0", bus.in_ready, 0);
        bus.opSel = OP_ADD; bus.operand1 = 32'd1; bus.operand2 = 32'd2;
        for (int i = 1; i <= 32; i++) begin
            tick();
            chk("mul_busy", bus.busy, 1);
            chk("mul_novld", bus.out_valid, 0);
            if (i == 16) chk("mul_hi_hold", bus.hi, 0);
        end
        tick();
        chk("mul_vld", bus.out_valid, 1);
        chk("mul_busy_done", bus.busy, 0);
        chk("mul_hi", bus.hi, 32'hFFFFFFFF);
        chk("mul_lo", bus.lo, 32'hFFFFFFF1);
        chk("mul_res", bus.result, 32'hFFFFFFF1);
        bus.in_valid = 1'b0;
        tick();
        chk("mul_pulse", bus.out_valid, 0);
        chk("mul_idle", bus.in_ready, 1);

        run_multi("mulu", OP_MULU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
        single("mfhi", OP_MFHI, 32'h0, 32'h0, 32'h00000001);
        single("mflo", OP_MFLO, 32'h0, 32'h0, 32'hFFFFFFFE);

`ifdef ALU_SEQ_DIV_EN
        run_multi("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_multi("divu_z", OP_DIVU, 32'd9, 32'd0, 32'h00000009, 32'hFFFFFFFF);
        run_multi("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run_multi("div_negz", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        bus.opSel = OP_DIV;
`else
        single("div_undef", OP_DIV, 32'd7, 32'd2, 32'h0);
        chk("div_undef_hi", bus.hi, 32'h00000001);
        chk("div_undef_lo", bus.lo, 32'hFFFFFFFE);
        single("divu_undef", OP_DIVU, 32'd9, 32'd0, 32'h0);
        bus.opSel = OP_MUL;
`endif

        // Reset mid-iteration aborts without a completion pulse.
        bus.operand1 = 32'd100; bus.operand2 = 32'd3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        chk("abort_busy_pre", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("abort_ready", bus.in_ready, 1);
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_zero", bus.zero, 1);
        pulses = 0;
        repeat (40) begin
            tick();
            if (bus.out_valid) pulses++;
        end
        chk("abort_pulses", pulses, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
